// File: rtl/ibex_multdiv_arbiter_pkg.sv
// ============================================================================
// Module   : ibex_multdiv_arbiter_pkg
// Brief    : Shared types for the multdiv arbiter and its round-robin picker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ibex_multdiv_arbiter_pkg;

   typedef enum logic [1:0] {
      MD_OP_MULL = 2'b00,
      MD_OP_MULH = 2'b01,
      MD_OP_DIV  = 2'b10,
      MD_OP_REM  = 2'b11
   } md_op_e;

   typedef enum logic {
      MD_ARB_IDLE = 1'b0,
      MD_ARB_BUSY = 1'b1
   } md_arb_state_e;

endpackage

`default_nettype wire

// File: rtl/ibex_rr_arbiter.sv
// ============================================================================
// Module   : ibex_rr_arbiter
// Brief    : Combinational round-robin pick: first request at or above prio.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_rr_arbiter #(
   parameter int unsigned NumReq = 2,
   parameter int unsigned IdxW   = $clog2(NumReq)
) (
   input  logic [NumReq-1:0] req,
   input  logic [IdxW-1:0]   prio,
   output logic [NumReq-1:0] gnt,
   output logic [IdxW-1:0]   idx
);

   int                w_cand;
   logic [IdxW-1:0]   w_pos;
   logic              w_found;

   // Wrap is an explicit subtraction so non-power-of-two counts never alias.
   always_comb begin
      gnt     = '0;
      idx     = '0;
      w_found = 1'b0;
      w_cand  = 0;
      w_pos   = '0;
      for (int k = 0; k < int'(NumReq); k++) begin
         w_cand = int'(prio) + k;
         if (w_cand >= int'(NumReq)) begin
            w_cand = w_cand - int'(NumReq);
         end
         w_pos = w_cand[IdxW-1:0];
         if (!w_found && req[w_pos]) begin
            w_found    = 1'b1;
            gnt[w_pos] = 1'b1;
            idx        = w_pos;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ibex_multdiv_arbiter.sv
// ============================================================================
// Module   : ibex_multdiv_arbiter
// Brief    : Round-robin sharing of one multi-cycle multdiv unit with abort.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_multdiv_arbiter
   import ibex_multdiv_arbiter_pkg::*;
#(
   parameter int unsigned NumReq    = 2,
   parameter int unsigned DataWidth = 32
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,

   input  logic [NumReq-1:0]                req_valid_i,
   output logic [NumReq-1:0]                req_ready_o,
   input  logic [NumReq-1:0][1:0]           req_operator_i,
   input  logic [NumReq-1:0][1:0]           req_signed_mode_i,
   input  logic [NumReq-1:0][DataWidth-1:0] req_op_a_i,
   input  logic [NumReq-1:0][DataWidth-1:0] req_op_b_i,
   input  logic [NumReq-1:0]                req_abort_i,
   output logic [NumReq-1:0]                rsp_valid_o,
   output logic [DataWidth-1:0]             rsp_result_o,

   output logic                             md_en_o,
   output md_op_e                           md_operator_o,
   output logic [1:0]                       md_signed_mode_o,
   output logic [DataWidth-1:0]             md_op_a_o,
   output logic [DataWidth-1:0]             md_op_b_o,
   output logic                             md_abort_o,
   input  logic                             md_valid_i,
   input  logic [DataWidth-1:0]             md_result_i
);

   localparam int unsigned      IDX_W    = $clog2(NumReq);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NumReq - 1);
   localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

   md_arb_state_e         r_state;
   md_arb_state_e         w_state_d;
   logic [IDX_W-1:0]      r_prio;
   logic [IDX_W-1:0]      r_owner;
   md_op_e                r_operator;
   logic [1:0]            r_signed_mode;
   logic [DataWidth-1:0]  r_op_a;
   logic [DataWidth-1:0]  r_op_b;

   logic [NumReq-1:0]     w_gnt;
   logic [IDX_W-1:0]      w_gnt_idx;
   logic                  w_grant_en;
   logic                  w_rotate;
   logic                  w_owner_abort;
   logic                  w_busy;

   ibex_rr_arbiter #(
      .NumReq (NumReq),
      .IdxW   (IDX_W)
   ) u_rr_arbiter (
      .req  (req_valid_i),
      .prio (r_prio),
      .gnt  (w_gnt),
      .idx  (w_gnt_idx)
   );

   assign w_busy        = (r_state == MD_ARB_BUSY);
   assign w_owner_abort = req_abort_i[r_owner];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state       <= MD_ARB_IDLE;
         r_prio        <= '0;
         r_owner       <= '0;
         r_operator    <= MD_OP_MULL;
         r_signed_mode <= '0;
         r_op_a        <= '0;
         r_op_b        <= '0;
      end else begin
         r_state <= w_state_d;
         if (w_grant_en) begin
            r_owner       <= w_gnt_idx;
            r_operator    <= md_op_e'(req_operator_i[w_gnt_idx]);
            r_signed_mode <= req_signed_mode_i[w_gnt_idx];
            r_op_a        <= req_op_a_i[w_gnt_idx];
            r_op_b        <= req_op_b_i[w_gnt_idx];
         end
         if (w_rotate) begin
            r_prio <= (r_owner == LAST_IDX) ? '0 : r_owner + ONE_IDX;
         end
      end
   end

   // Abort is checked ahead of md_valid_i so a colliding result is dropped.
   always_comb begin
      w_state_d    = r_state;
      w_grant_en   = 1'b0;
      w_rotate     = 1'b0;
      req_ready_o  = '0;
      rsp_valid_o  = '0;
      rsp_result_o = '0;
      md_abort_o   = 1'b0;
      case (r_state)
         MD_ARB_IDLE: begin
            if (rst_ni && (|req_valid_i)) begin
               req_ready_o = w_gnt;
               w_grant_en  = 1'b1;
               w_state_d   = MD_ARB_BUSY;
            end
         end
         MD_ARB_BUSY: begin
            if (w_owner_abort) begin
               md_abort_o = 1'b1;
               w_rotate   = 1'b1;
               w_state_d  = MD_ARB_IDLE;
            end else if (md_valid_i) begin
               rsp_valid_o[r_owner] = 1'b1;
               rsp_result_o         = md_result_i;
               w_rotate             = 1'b1;
               w_state_d            = MD_ARB_IDLE;
            end
         end
         default: begin
            w_state_d = MD_ARB_IDLE;
         end
      endcase
   end

   // Latched values are only presented while the unit is owned.
   assign md_en_o          = w_busy;
   assign md_operator_o    = w_busy ? r_operator : MD_OP_MULL;
   assign md_signed_mode_o = w_busy ? r_signed_mode : 2'b00;
   assign md_op_a_o        = w_busy ? r_op_a : '0;
   assign md_op_b_o        = w_busy ? r_op_b : '0;

`ifndef SYNTHESIS
   a_no_result_when_idle : assert property (
      @(posedge clk_i) disable iff (!rst_ni) !(md_valid_i && (r_state == MD_ARB_IDLE))
   );
`endif

endmodule

`default_nettype wire

// File: tb/tb_ibex_multdiv_arbiter.sv
// ============================================================================
// Module   : tb_ibex_multdiv_arbiter
// Brief    : Directed self-checking bench for the shared multdiv arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibex_multdiv_arbiter;
   import ibex_multdiv_arbiter_pkg::*;

   logic              clk;
   logic              rst_n;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0][1:0]   req_operator;
   logic [1:0][1:0]   req_signed;
   logic [1:0][31:0]  op_a;
   logic [1:0][31:0]  op_b;
   logic [1:0]        req_abort;
   logic [1:0]        rsp_valid;
   logic [31:0]       rsp_result;
   logic              md_en;
   md_op_e            md_operator;
   logic [1:0]        md_signed;
   logic [31:0]       md_op_a;
   logic [31:0]       md_op_b;
   logic              md_abort;
   logic              md_valid;
   logic [31:0]       md_result;

   int                checks;
   int                errors;
   logic [1:0]        exp_g;

   ibex_multdiv_arbiter #(
      .NumReq    (2),
      .DataWidth (32)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .req_valid_i       (req_valid),
      .req_ready_o       (req_ready),
      .req_operator_i    (req_operator),
      .req_signed_mode_i (req_signed),
      .req_op_a_i        (op_a),
      .req_op_b_i        (op_b),
      .req_abort_i       (req_abort),
      .rsp_valid_o       (rsp_valid),
      .rsp_result_o      (rsp_result),
      .md_en_o           (md_en),
      .md_operator_o     (md_operator),
      .md_signed_mode_o  (md_signed),
      .md_op_a_o         (md_op_a),
      .md_op_b_o         (md_op_b),
      .md_abort_o        (md_abort),
      .md_valid_i        (md_valid),
      .md_result_i       (md_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst_n        = 1'b0;
      req_valid    = '0;
      req_operator = '0;
      req_signed   = '0;
      op_a         = '0;
      op_b         = '0;
      req_abort    = '0;
      md_valid     = 1'b0;
      md_result    = '0;

      // Reset state
      #2;
      chk("rst_ready", req_ready, 0);
      chk("rst_md_en", md_en, 0);
      chk("rst_operator", md_operator, MD_OP_MULL);
      chk("rst_op_a", md_op_a, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_abort", md_abort, 0);
      req_valid = 2'b01;
      #1;
      chk("rst_ready_gated", req_ready, 0);
      req_valid = 2'b00;
      tick();
      rst_n = 1'b1;
      #1;

      // Contention from prio 0: grants alternate 0,1,0,1
      req_valid    = 2'b11;
      op_a[0]      = 32'd10;
      op_a[1]      = 32'd20;
      op_b[0]      = 32'd1;
      op_b[1]      = 32'd2;
      req_operator = {MD_OP_DIV, MD_OP_MULL};
      for (int i = 0; i < 4; i++) begin
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         chk("cont_idle_md_en", md_en, 0);
         chk("cont_gnt", req_ready, exp_g);
         tick();
         md_valid  = 1'b1;
         md_result = 32'd100 + i;
         #1;
         chk("cont_busy_ready", req_ready, 0);
         chk("cont_op_a", md_op_a, (exp_g == 2'b01) ? 32'd10 : 32'd20);
         chk("cont_rsp_valid", rsp_valid, exp_g);
         chk("cont_rsp_result", rsp_result, 32'd100 + i);
         tick();
         md_valid = 1'b0;
      end

      // Single request from requester 0 (prio back at 0)
      req_valid       = 2'b01;
      req_operator[0] = MD_OP_MULL;
      op_a[0]         = 32'd3;
      op_b[0]         = 32'd5;
      #1;
      chk("single_gnt", req_ready, 2'b01);
      chk("single_idle_md_en", md_en, 0);
      tick();
      req_valid = 2'b00;
      #1;
      chk("single_md_en", md_en, 1);
      chk("single_op_a", md_op_a, 3);
      chk("single_op_b", md_op_b, 5);
      chk("single_operator", md_operator, MD_OP_MULL);
      chk("single_no_rsp", rsp_valid, 0);
      chk("single_rsp_zero", rsp_result, 0);
      tick();
      md_valid  = 1'b1;
      md_result = 32'd15;
      #1;
      chk("single_rsp_valid", rsp_valid, 2'b01);
      chk("single_rsp_result", rsp_result, 15);
      tick();
      md_valid = 1'b0;
      #1;
      chk("single_back_idle", md_en, 0);
      chk("single_rsp_clear", rsp_valid, 0);

      // Operand stability on requester 1 (prio now 1)
      req_valid       = 2'b10;
      req_operator[1] = MD_OP_MULH;
      req_signed[1]   = 2'b11;
      op_a[1]         = 32'd7;
      op_b[1]         = 32'd2;
      #1;
      chk("stab_gnt", req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      op_a[1]   = 32'd9;
      #1;
      chk("stab_op_a_1", md_op_a, 7);
      chk("stab_signed", md_signed, 2'b11);
      chk("stab_operator", md_operator, MD_OP_MULH);
      tick();
      #1;
      chk("stab_op_a_2", md_op_a, 7);
      md_valid  = 1'b1;
      md_result = 32'd14;
      #1;
      chk("stab_rsp_valid", rsp_valid, 2'b10);
      chk("stab_rsp_result", rsp_result, 14);
      tick();
      md_valid = 1'b0;

      // Abort by owner 1 in its third busy cycle (prio now 0)
      req_valid = 2'b10;
      op_a[1]   = 32'd4;
      #1;
      chk("abort_gnt", req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      tick();
      req_abort = 2'b01;
      #1;
      chk("abort_nonowner_ignored", md_abort, 0);
      chk("abort_nonowner_busy", md_en, 1);
      tick();
      req_abort = 2'b10;
      #1;
      chk("abort_pulse", md_abort, 1);
      chk("abort_no_rsp", rsp_valid, 0);
      tick();
      req_abort = 2'b00;
      #1;
      chk("abort_idle", md_en, 0);
      chk("abort_pulse_done", md_abort, 0);
      req_valid = 2'b11;
      #1;
      chk("abort_next_gnt", req_ready, 2'b01);
      tick();

      // Abort colliding with md_valid_i on owner 0
      md_valid  = 1'b1;
      md_result = 32'd99;
      req_abort = 2'b01;
      #1;
      chk("coll_abort", md_abort, 1);
      chk("coll_no_rsp", rsp_valid, 0);
      chk("coll_rsp_zero", rsp_result, 0);
      tick();
      md_valid  = 1'b0;
      req_abort = 2'b00;
      #1;
      chk("coll_idle", md_en, 0);
      chk("coll_prio_adv", req_ready, 2'b10);
      tick();

      // Asynchronous reset in the middle of an operation
      #1;
      chk("rstmid_busy", md_en, 1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_md_en", md_en, 0);
      chk("rstmid_op_a", md_op_a, 0);
      chk("rstmid_ready", req_ready, 0);
      chk("rstmid_signed", md_signed, 0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("rstmid_first_gnt", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      md_valid  = 1'b1;
      md_result = 32'd42;
      #1;
      chk("rstmid_rsp", rsp_valid, 2'b01);
      tick();
      md_valid = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
